key_event_gen: RTL and testbench



---
 rtl/key_event_gen_if.sv | 27 ++
 rtl/key_event_gen.sv | 158 +++++++++++++++
 tb/tb_key_event_gen.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/key_event_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// key_event_gen_if : raw keys in, clean per-key events out
// Rev 1.0
// ============================================================================
interface key_event_gen_if;
    logic [1:0] Key_In;
    logic [1:0] Key_Level;
    logic [1:0] Key_Press;
    logic [1:0] Key_Hold;

    modport master (
        input  Key_In,
        output Key_Level,
        output Key_Press,
        output Key_Hold
    );

    modport slave (
        output Key_In,
        input  Key_Level,
        input  Key_Press,
        input  Key_Hold
    );
endinterface
`default_nettype wire

// File: rtl/key_event_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// key_event_gen : debounce, press pulse and auto-repeat for two push-buttons
// Rev 1.0
// ============================================================================
module key_event_gen #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  wire logic        Sys_CLK,
    input  wire logic        Sys_RST,
    key_event_gen_if.master  key_if
);

    localparam int DW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW       = $clog2(HOLD_MAX) + 1;

    localparam logic [DW-1:0] DEB_ONE     = DW'(1);
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE    = HW'(1);
    localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DEB_PRESS   = 3'd1,
        PRESSED     = 3'd2,
        REPEAT      = 3'd3,
        DEB_RELEASE = 3'd4
    } state_t;

    logic [1:0] sync1, sync2, s;
    logic [1:0] level_w, press_w, hold_w;

    always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
        if (!Sys_RST) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= key_if.Key_In;
            sync2 <= sync1;
        end
    end

    assign s = ~sync2;

    for (genvar i = 0; i < 2; i++) begin : g_key
        state_t          state, state_nx;
        logic [DW-1:0]   deb_cnt, deb_nx;
        logic [HW-1:0]   hold_cnt, hold_nx, hold_term;
        logic            level, level_nx;
        logic            hold, hold_flag_nx;
        logic            press, press_nx;

        always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
            if (!Sys_RST) begin
                state    <= IDLE;
                deb_cnt  <= '0;
                hold_cnt <= '0;
                level    <= 1'b0;
                hold     <= 1'b0;
                press    <= 1'b0;
            end else begin
                state    <= state_nx;
                deb_cnt  <= deb_nx;
                hold_cnt <= hold_nx;
                level    <= level_nx;
                hold     <= hold_flag_nx;
                press    <= press_nx;
            end
        end

        assign hold_term = (state == PRESSED) ? DELAY_LAST : PERIOD_LAST;

        always_comb begin
            state_nx     = state;
            deb_nx       = deb_cnt;
            hold_nx      = hold_cnt;
            level_nx     = level;
            hold_flag_nx = hold;
            press_nx     = 1'b0;
            case (state)
                IDLE: begin
                    if (s[i]) begin
                        state_nx = DEB_PRESS;
                        deb_nx   = DEB_ONE;
                    end else begin
                        deb_nx   = '0;
                    end
                end
                DEB_PRESS: begin
                    if (!s[i]) begin
                        state_nx = IDLE;
                        deb_nx   = '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state_nx = PRESSED;
                        deb_nx   = '0;
                        hold_nx  = '0;
                        level_nx = 1'b1;
                        press_nx = 1'b1;
                    end else begin
                        deb_nx   = deb_cnt + DEB_ONE;
                    end
                end
                PRESSED, REPEAT: begin
                    // A release seen exactly at the terminal count parks the
                    // counter there, so the pulse fires on the first held cycle back.
                    if (!s[i]) begin
                        state_nx = DEB_RELEASE;
                        deb_nx   = DEB_ONE;
                        if (hold_cnt != hold_term)
                            hold_nx = hold_cnt + HOLD_ONE;
                    end else if (hold_cnt == hold_term) begin
                        state_nx     = REPEAT;
                        hold_nx      = '0;
                        hold_flag_nx = 1'b1;
                        press_nx     = REPEAT_EN;
                    end else begin
                        hold_nx = hold_cnt + HOLD_ONE;
                    end
                end
                DEB_RELEASE: begin
                    if (s[i]) begin
                        state_nx = hold ? REPEAT : PRESSED;
                        deb_nx   = '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state_nx     = IDLE;
                        deb_nx       = '0;
                        hold_nx      = '0;
                        level_nx     = 1'b0;
                        hold_flag_nx = 1'b0;
                    end else begin
                        deb_nx = deb_cnt + DEB_ONE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    deb_nx   = '0;
                    hold_nx  = '0;
                end
            endcase
        end

        assign level_w[i] = level;
        assign press_w[i] = press;
        assign hold_w[i]  = hold;
    end

    assign key_if.Key_Level = level_w;
    assign key_if.Key_Press = press_w;
    assign key_if.Key_Hold  = hold_w;

endmodule
`default_nettype wire

// File: tb/tb_key_event_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_key_event_gen : directed and random key stimulus against a run-length model
// Rev 1.0
// ============================================================================
module tb_key_event_gen;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;
    localparam bit EN  = 1'b1;

    logic Sys_CLK = 1'b0;
    logic Sys_RST = 1'b0;
    key_event_gen_if kif();

    key_event_gen #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .REPEAT_EN      (EN)
    ) dut (
        .Sys_CLK(Sys_CLK),
        .Sys_RST(Sys_RST),
        .key_if (kif)
    );

    always #5 Sys_CLK = ~Sys_CLK;

    int checks = 0;
    int errors = 0;

    // Reference: a key is accepted after DEB consecutive pressed samples and
    // let go after DEB consecutive released samples; held time accumulates
    // for every cycle in which the key was seen pressed one sample earlier.
    logic [1:0] m_sync1, m_sync2, m_level, m_press, m_hold, m_sprev;
    int run1 [2];
    int run0 [2];
    int acc  [2];
    int tgt  [2];

    task automatic model_reset();
        m_sync1 = 2'b11; m_sync2 = 2'b11;
        m_level = 2'b00; m_press = 2'b00; m_hold = 2'b00; m_sprev = 2'b00;
        for (int i = 0; i < 2; i++) begin
            run1[i] = 0; run0[i] = 0; acc[i] = 0; tgt[i] = RD;
        end
    endtask

    task automatic model_tick(input logic [1:0] k);
        logic sv;
        if (!Sys_RST) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                sv = ~m_sync2[i];
                m_press[i] = 1'b0;
                if (!m_level[i]) begin
                    run1[i] = sv ? run1[i] + 1 : 0;
                    if (run1[i] == DEB) begin
                        m_level[i] = 1'b1; m_press[i] = 1'b1;
                        acc[i] = 0; tgt[i] = RD; run0[i] = 0;
                    end
                end else begin
                    run0[i] = sv ? 0 : run0[i] + 1;
                    if (run0[i] == DEB) begin
                        m_level[i] = 1'b0; m_hold[i] = 1'b0;
                        run0[i] = 0; run1[i] = 0;
                    end else if (m_sprev[i]) begin
                        if (acc[i] + 1 == tgt[i]) begin
                            if (sv) begin
                                acc[i]++; tgt[i] += RP;
                                m_hold[i] = 1'b1; m_press[i] = EN;
                            end
                        end else begin
                            acc[i]++;
                        end
                    end
                end
                m_sprev[i] = sv;
            end
            m_sync2 = m_sync1;
            m_sync1 = k;
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic [1:0] k);
        kif.Key_In = k;
        @(posedge Sys_CLK);
        model_tick(k);
        #1;
        chk("level", kif.Key_Level, m_level);
        chk("press", kif.Key_Press, m_press);
        chk("hold",  kif.Key_Hold,  m_hold);
    endtask

    task automatic pulse_reset();
        #2 Sys_RST = 1'b0;
        #1;
        model_reset();
        chk("rst_level", kif.Key_Level, 2'b00);
        chk("rst_press", kif.Key_Press, 2'b00);
        chk("rst_hold",  kif.Key_Hold,  2'b00);
        step(kif.Key_In);
        step(kif.Key_In);
        #1 Sys_RST = 1'b1;
    endtask

    logic [1:0] k;
    int len [2];
    int rep_cnt;

    initial begin
        model_reset();
        kif.Key_In = 2'b11;
        step(2'b11);
        step(2'b11);
        chk("reset_level", kif.Key_Level, 2'b00);
        chk("reset_press", kif.Key_Press, 2'b00);
        chk("reset_hold",  kif.Key_Hold,  2'b00);
        #2 Sys_RST = 1'b1;
        step(2'b11);
        step(2'b11);

        // Clean press on key 0, 10 cycles, then release
        for (int i = 1; i <= 10; i++) begin
            step(2'b10);
            if (i == 6) chk("s1_press_at6", kif.Key_Press, 2'b01);
            if (i == 5) chk("s1_no_press_at5", kif.Key_Press, 2'b00);
        end
        for (int i = 1; i <= 8; i++) begin
            step(2'b11);
            if (i == 5) chk("s1_level_still", kif.Key_Level, 2'b01);
            if (i == 6) chk("s1_level_fall", kif.Key_Level, 2'b00);
        end

        // Bouncing key 1
        step(2'b01); step(2'b01); step(2'b11);
        step(2'b01); step(2'b01); step(2'b11);
        for (int i = 1; i <= 12; i++) begin
            step(2'b01);
            if (i == 6) chk("s2_press_at6", kif.Key_Press, 2'b10);
        end
        for (int i = 0; i < 10; i++) step(2'b11);

        // Long hold on key 0 with auto-repeat
        rep_cnt = 0;
        for (int i = 1; i <= 60; i++) begin
            step(2'b10);
            if (i > 6 && kif.Key_Press[0]) rep_cnt++;
            if (i == 26) chk("s3_first_repeat", {kif.Key_Hold[0], kif.Key_Press[0]}, 2'b11);
        end
        chk("s3_repeat_count", rep_cnt[1:0], 2'b01);
        for (int i = 1; i <= 8; i++) begin
            step(2'b11);
            if (i == 6) chk("s3_hold_clear", kif.Key_Hold, 2'b00);
        end

        // Both keys on the same edge
        for (int i = 1; i <= 10; i++) begin
            step(2'b00);
            if (i == 6) chk("s4_both_press", kif.Key_Press, 2'b11);
            if (i == 6) chk("s4_both_level", kif.Key_Level, 2'b11);
        end
        for (int i = 0; i < 10; i++) step(2'b11);

        // Release glitch during hold
        for (int i = 1; i <= 35; i++) begin
            step((i == 15 || i == 16) ? 2'b11 : 2'b10);
            if (i == 26) chk("s5_no_repeat_at20", kif.Key_Press, 2'b00);
            if (i == 28) chk("s5_repeat_at22", kif.Key_Press, 2'b01);
        end
        for (int i = 0; i < 10; i++) step(2'b11);

        // Reset while repeating with the key still held
        for (int i = 1; i <= 30; i++) step(2'b10);
        pulse_reset();
        for (int i = 1; i <= 30; i++) begin
            step(2'b10);
            if (i == 6)  chk("s6_fresh_press", kif.Key_Press, 2'b01);
            if (i == 26) chk("s6_repeat_restart", kif.Key_Press, 2'b01);
        end
        for (int i = 0; i < 10; i++) step(2'b11);

        // Random run-length stimulus on both keys
        k = 2'b11;
        len[0] = 0;
        len[1] = 0;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (len[i] == 0) begin
                    k[i] = ~k[i];
                    len[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                                         : int'($urandom_range(4, 60));
                end
                len[i]--;
            end
            step(k);
            if ($urandom_range(0, 399) == 0) pulse_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
